// File: rtl/imem_pkg.sv
// Shared types and width helpers for the instruction-memory fetch responder.
package imem_pkg;

  // A64 NOP, returned in place of the word for misaligned or out-of-range fetches.
  localparam logic [31:0] A64_NOP = 32'hD503201F;

  // One fetch response as it travels through the latency pipe and the output FIFO.
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] addr;
    logic        err;
  } rsp_t;

  // Index width for a power-of-two table; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO. Pointers carry one extra wrap bit for full/empty.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = idx_width(FIFO_DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  rsp_t          push_data,
  input  logic          pop,
  output rsp_t          pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rsp_t          mem [FIFO_DEPTH];
  logic [CW-1:0] wptr_q;
  logic [CW-1:0] rptr_q;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign count    = wptr_q - rptr_q;
  assign pop_data = mem[rptr_q[AW-1:0]];
  assign do_pop   = pop && !empty;
  // A pop on the same edge frees the slot, so a push while full is still honoured.
  assign do_push  = push && (!full || do_pop);

  // Advance read/write pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + CW'(1);
      if (do_pop)  rptr_q <= rptr_q + CW'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: decodes fetch addresses, reads the word on acceptance,
// delays it by a fixed pipe and buffers it in an in-order response FIFO.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned IW = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic [63:0]   rsp_addr,
  output logic          rsp_err,
  input  logic          load_en,
  input  logic [IW-1:0] load_idx,
  input  logic [31:0]   load_data
);

  localparam int unsigned CW = idx_width(FIFO_DEPTH) + 1;

  logic [31:0]        mem [DEPTH];
  logic [LATENCY-1:0] pipe_vld_q;
  rsp_t               pipe_q [LATENCY];
  logic               accept;
  logic               pop;
  logic [IW-1:0]      dec_idx;
  logic               dec_err;
  logic [CW-1:0]      outstanding;
  rsp_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign dec_idx = req_addr[IW+1:2];
  // Power-of-two depth: out of range exactly when any bit above the index is set.
  assign dec_err = (req_addr[1:0] != 2'b00) || (req_addr[63:IW+2] != '0);
  assign accept  = req_valid && req_ready;
  assign pop     = rsp_valid && rsp_ready;

  // Credits: everything in the pipe already owns a FIFO slot, so the pipe never stalls.
  always_comb begin
    outstanding = fifo_count;
    for (int i = 0; i < LATENCY; i++) outstanding = outstanding + CW'(pipe_vld_q[i]);
  end

  assign req_ready = rst_n && !fifo_full && (outstanding < CW'(FIFO_DEPTH));

  // Program load port; honoured in and out of reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
  end

  // Latency pipe valids; accepted requests enter stage 0 on the acceptance edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // Latency pipe payload; reading mem here gives read-before-write against load_en.
  always_ff @(posedge clk) begin
    pipe_q[0].inst <= dec_err ? A64_NOP : mem[dec_idx];
    pipe_q[0].addr <= req_addr;
    pipe_q[0].err  <= dec_err;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  imem_rsp_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld_q[LATENCY-1]),
    .push_data (pipe_q[LATENCY-1]),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Response outputs read zero whenever nothing is buffered.
  always_comb begin
    rsp_valid = !fifo_empty;
    rsp_inst  = '0;
    rsp_addr  = '0;
    rsp_err   = 1'b0;
    if (!fifo_empty) begin
      rsp_inst = head.inst;
      rsp_addr = head.addr;
      rsp_err  = head.err;
    end
  end

endmodule
